div_iter: RTL

Iterative 32-bit radix-2 divider that serves the ALU's divide requests. It answers the start/annul/ready handshake the ALU drives for DIV and DIVU, and returns `{remainder, quotient}` in HI/LO layout. Signed and unsigned modes are supported. While the ALU holds `start_i`, the pipeline stalls until `ready_o` rises.

---
 rtl/div_iter_if.sv | 21 ++
 rtl/div_iter.sv | 101 ++++++++++
 2 files changed

// File: rtl/div_iter_if.sv
// Divide request/response bundle between the ALU (master) and div_iter (slave).
// Carries operands, mode, the start/annul handshake and the HI/LO result.
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] a;
  logic [31:0] b;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, a, b, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, a, b, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider, signed or unsigned, one quotient
// bit per cycle; returns {remainder, quotient} with a one-cycle ready pulse.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  div_iter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DIVBY0, ON, END} state_e;

  state_e      state, state_d;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, divisor;
  logic        qneg, rneg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_step, quo_step;
  logic [63:0] result_d;
  logic        ready_d;
  logic        start_ok, abort;

  assign start_ok = (state == IDLE) && bus.start_i && !bus.annul_i;
  assign abort    = bus.annul_i || !bus.start_i;
  assign abs_a    = (bus.signed_div_i && bus.a[31]) ? -bus.a : bus.a;
  assign abs_b    = (bus.signed_div_i && bus.b[31]) ? -bus.b : bus.b;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state;
    unique case (state)
      IDLE:    if (start_ok) state_d = (bus.b == 32'd0) ? DIVBY0 : ON;
      DIVBY0:  state_d = abort ? IDLE : END;
      ON:      if (abort) state_d = IDLE;
               else if (cnt == 5'd31) state_d = END;
      END:     if (abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step. The remainder always stays below the divisor, so its
  // top bit is only needed transiently in the shifted 33-bit value.
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[32]) begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end else begin
      rem_step = rem_sh[31:0];
      quo_step = {quo[30:0], 1'b0};
    end
  end

  // Output logic: next values of the registered result and ready.
  always_comb begin
    result_d = bus.result_o;
    ready_d  = (state_d == END);
    if (state == ON && state_d == END)
      result_d = {rneg ? -rem_step : rem_step, qneg ? -quo_step : quo_step};
    else if (state == DIVBY0 && state_d == END)
      result_d = 64'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 5'd0;
      bus.result_o <= 64'h0;
      bus.ready_o  <= 1'b0;
    end else begin
      bus.result_o <= result_d;
      bus.ready_o  <= ready_d;
      if (state == ON) cnt <= cnt + 5'd1;
      else             cnt <= 5'd0;
    end
  end

  // NOTE: the working registers carry no reset; they are always loaded on the
  // accepting IDLE cycle before anything reads them.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      rem     <= 32'd0;
      quo     <= abs_a;
      divisor <= abs_b;
      qneg    <= bus.signed_div_i && (bus.a[31] ^ bus.b[31]);
      rneg    <= bus.signed_div_i && bus.a[31];
    end else if (state == ON) begin
      rem <= rem_step;
      quo <= quo_step;
    end
  end

endmodule
